fp16_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single multi-cycle FP16 logarithmic multiplier core among `NREQ` requesters. Each requester presents an FP16 operand pair over a valid/ready handshake. The arbiter grants one request at a time and issues it to the core with a start pulse. It waits for the core's done flag, bounded by a watchdog, and returns the 16-bit product, or an error, to the granting requester over a valid/ready response channel. It sits between the client logic and the multiplier core; the core itself is unchanged.

---
 rtl/fp16_mul_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fp16_mul_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin front end that shares one multi-cycle
// FP16 multiplier core among NREQ requesters, with a done watchdog.
module fp16_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [16*NREQ-1:0]        req_a_i,
  input  logic [16*NREQ-1:0]        req_b_i,
  output logic [NREQ-1:0]           rsp_valid_o,
  input  logic [NREQ-1:0]           rsp_ready_i,
  output logic [15:0]               rsp_data_o,
  output logic                      rsp_err_o,
  output logic                      mul_start_o,
  output logic [15:0]               mul_a_o,
  output logic [15:0]               mul_b_o,
  input  logic                      mul_done_i,
  input  logic [15:0]               mul_result_i,
  output logic                      busy_o,
  output logic [$clog2(NREQ)-1:0]   grant_id_o
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Quiet NaN returned when the core never answers.
  localparam logic [15:0] QNAN = 16'h7E00;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     mul_a_q, mul_a_d;
  logic [15:0]     mul_b_q, mul_b_d;
  logic            mul_start_q, mul_start_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;

  logic            gnt_vld;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand;

  // (p + i) mod NREQ without relying on NREQ being a power of two.
  function automatic logic [IW-1:0] wrap_idx(
    input logic [IW-1:0] p,
    input int            i
  );
    int s;
    s = int'(p) + i;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Search for the first valid requester starting at ptr, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      cand = wrap_idx(ptr_q, i);
      if (!gnt_vld && req_valid_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Ready only in IDLE and only toward the winner of the search.
  always_comb begin
    req_ready_o = '0;
    if (state_q == S_IDLE && gnt_vld) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  // Sequencer: accept, issue, wait for done or watchdog, respond.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_start_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          mul_a_d     = req_a_i[16*int'(gnt_idx) +: 16];
          mul_b_d     = req_b_i[16*int'(gnt_idx) +: 16];
          grant_id_d  = gnt_idx;
          ptr_d       = wrap_idx(gnt_idx, 1);
          mul_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A done in the final watchdog cycle still counts as success.
        if (mul_done_i) begin
          rsp_data_d              = mul_result_i;
          rsp_err_d               = 1'b0;
          rsp_valid_d             = '0;
          rsp_valid_d[grant_id_q] = 1'b1;
          state_d                 = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_data_d              = QNAN;
          rsp_err_d               = 1'b1;
          rsp_valid_d             = '0;
          rsp_valid_d[grant_id_q] = 1'b1;
          state_d                 = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i[grant_id_q]) begin
          rsp_valid_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset discards any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign mul_start_o = mul_start_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign busy_o      = busy_q;
  assign grant_id_o  = grant_id_q;

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter with a mock multiplier core
// whose done latency is programmable (0 = never answers).
module tb_fp16_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready = '0;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        mul_start;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_done;
  logic [15:0] mul_result;
  logic        busy;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  int          mock_lat = 1;
  logic [15:0] mock_res = '0;
  logic        done_q;
  logic        inj_done = 1'b0;
  int          cd;

  always #5 clk = ~clk;

  fp16_mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err),
    .mul_start_o  (mul_start),
    .mul_a_o      (mul_a),
    .mul_b_o      (mul_b),
    .mul_done_i   (mul_done),
    .mul_result_i (mul_result),
    .busy_o       (busy),
    .grant_id_o   (grant_id)
  );

  // Mock core: done pulse mock_lat cycles after the start cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cd     <= 0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mul_start) begin
        if (mock_lat == 1) done_q <= 1'b1;
        else if (mock_lat > 1) cd <= mock_lat - 1;
      end else if (cd > 1) begin
        cd <= cd - 1;
      end else if (cd == 1) begin
        cd     <= 0;
        done_q <= 1'b1;
      end
    end
  end

  assign mul_done   = done_q | inj_done;
  assign mul_result = mock_res;

  typedef struct {
    int          r;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [15:0] res;
    logic [15:0] exp_d;
    logic        exp_e;
    int          exp_n;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '0;
    inj_done  = 1'b0;
    rst       = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (req_ready == 4'b0 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) chk({nm, "_ready_timeout"}, 32'(n), 32'(0));
  endtask

  task automatic do_txn(input vec_t v);
    int n;
    mock_lat = v.lat;
    mock_res = v.res;
    req_a = '0;
    req_b = '0;
    req_a[16*v.r +: 16] = v.a;
    req_b[16*v.r +: 16] = v.b;
    req_valid = 4'(1 << v.r);
    #1;
    wait_ready("txn");
    chk("req_ready", 32'(req_ready), 32'(1 << v.r));
    step();
    req_valid = '0;
    chk("mul_start", 32'(mul_start), 32'(1));
    chk("mul_a", 32'(mul_a), 32'(v.a));
    chk("mul_b", 32'(mul_b), 32'(v.b));
    chk("grant_id", 32'(grant_id), 32'(v.r));
    chk("busy", 32'(busy), 32'(1));
    n = 0;
    while (rsp_valid == 4'b0 && n < 40) begin
      step();
      n++;
      if (n == 1) begin
        chk("start_pulse", 32'(mul_start), 32'(0));
        chk("mul_a_hold", 32'(mul_a), 32'(v.a));
      end
    end
    chk("latency", 32'(n), 32'(v.exp_n));
    chk("rsp_valid", 32'(rsp_valid), 32'(1 << v.r));
    chk("rsp_data", 32'(rsp_data), 32'(v.exp_d));
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_e));
    rsp_ready = 4'(1 << v.r);
    step();
    rsp_ready = '0;
    chk("rsp_clear", 32'(rsp_valid), 32'(0));
    chk("idle", 32'(busy), 32'(0));
  endtask

  task automatic get_grant(output int g);
    g = -1;
    wait_ready("rr");
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) g = i;
    end
    chk("rr_onehot", 32'($onehot(req_ready)), 32'(1));
    step();
  endtask

  initial begin
    int g;
    int n;
    int exp_rr[9];
    logic [15:0] held;

    tbl[0] = '{2, 16'h4000, 16'h4200, 6, 16'h4600, 16'h4600, 1'b0, 7};
    tbl[1] = '{0, 16'h3C00, 16'h3C00, 1, 16'h3C00, 16'h3C00, 1'b0, 2};
    tbl[2] = '{3, 16'hC000, 16'h4000, 16, 16'hC400, 16'hC400, 1'b0, 17};
    tbl[3] = '{1, 16'h5000, 16'h3800, 15, 16'h4C00, 16'h4C00, 1'b0, 16};
    tbl[4] = '{1, 16'h1234, 16'h5678, 0, 16'h0000, 16'h7E00, 1'b1, 17};
    tbl[5] = '{3, 16'h7BFF, 16'h0001, 3, 16'hABCD, 16'hABCD, 1'b0, 4};
    exp_rr = '{0, 1, 2, 3, 0, 1, 3, 1, 3};

    do_reset();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_mul_a", 32'(mul_a), 32'(0));
    chk("rst_grant", 32'(grant_id), 32'(0));
    chk("rst_start", 32'(mul_start), 32'(0));

    for (int i = 0; i < 6; i++) do_txn(tbl[i]);

    // Late done after a timeout must not alter or repeat the response.
    mock_lat  = 0;
    req_a     = '0;
    req_b     = '0;
    req_valid = 4'b0001;
    #1;
    wait_ready("late");
    step();
    req_valid = '0;
    n = 0;
    while (rsp_valid == 4'b0 && n < 40) begin
      step();
      n++;
    end
    chk("late_lat", 32'(n), 32'(17));
    inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    chk("late_data", 32'(rsp_data), 32'(16'h7E00));
    chk("late_err", 32'(rsp_err), 32'(1));
    chk("late_valid", 32'(rsp_valid), 32'(1));
    rsp_ready = 4'b0001;
    step();
    rsp_ready = '0;
    inj_done  = 1'b1;
    step();
    inj_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("late_no_rsp", 32'(rsp_valid), 32'(0));
      chk("late_no_busy", 32'(busy), 32'(0));
    end

    // Round-robin order.
    do_reset();
    mock_lat  = 1;
    req_a     = {4{16'h3C00}};
    req_b     = {4{16'h3C00}};
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    #1;
    for (int i = 0; i < 9; i++) begin
      get_grant(g);
      if (i == 5) req_valid = 4'b1010;
      chk("rr_order", 32'(g), 32'(exp_rr[i]));
    end
    req_valid = '0;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("rr_drain", 32'(busy), 32'(0));
    rsp_ready = '0;

    // Response backpressure; other rsp_ready bits are ignored.
    do_reset();
    mock_lat  = 1;
    mock_res  = 16'h4A00;
    req_valid = 4'b0011;
    #1;
    get_grant(g);
    chk("bp_grant", 32'(g), 32'(0));
    n = 0;
    while (rsp_valid == 4'b0 && n < 40) begin
      step();
      n++;
    end
    held = rsp_data;
    chk("bp_data", 32'(held), 32'(16'h4A00));
    rsp_ready = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_hold", 32'(rsp_data), 32'(held));
      chk("bp_busy", 32'(busy), 32'(1));
      chk("bp_noready", 32'(req_ready), 32'(0));
    end
    rsp_ready = 4'b0001;
    step();
    rsp_ready = '0;
    chk("bp_next", 32'(req_ready), 32'(4'b0010));
    step();
    req_valid = '0;
    rsp_ready = 4'hF;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("bp_drain", 32'(busy), 32'(0));
    rsp_ready = '0;

    // Asynchronous reset in the middle of WAIT.
    mock_lat  = 0;
    req_a     = '0;
    req_b     = '0;
    req_a[47:32] = 16'h4500;
    req_b[47:32] = 16'h4100;
    req_valid = 4'b0100;
    #1;
    wait_ready("rstw");
    step();
    req_valid = '0;
    step();
    step();
    step();
    chk("pre_rst_grant", 32'(grant_id), 32'(2));
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_grant", 32'(grant_id), 32'(0));
    chk("arst_mul_a", 32'(mul_a), 32'(0));
    chk("arst_mul_b", 32'(mul_b), 32'(0));
    chk("arst_rsp", 32'(rsp_valid), 32'(0));
    chk("arst_ready", 32'(req_ready), 32'(0));
    step();
    rst = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("arst_ptr0", 32'(req_ready), 32'(4'b0001));
    req_valid = '0;
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
